// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite evaluation slice.
// Build option: SPRITE_BYPASS_EN (see sprite_eval.sv).
package sprite_pkg;

  localparam int SCREEN_W    = 640;
  localparam int TILE_PX     = 8;
  localparam int SLICE_W     = 8;

  // Tile-row address layout: {table, row, col, pixel-row}
  localparam int PROW_W      = 3;
  localparam int TCOL_W      = 4;
  localparam int TROW_W      = 4;
  localparam int TILE_ADDR_W = 1 + TROW_W + TCOL_W + PROW_W;
  localparam int PROW_LSB    = 0;
  localparam int TCOL_LSB    = PROW_LSB + PROW_W;
  localparam int TROW_LSB    = TCOL_LSB + TCOL_W;
  localparam int TTBL_BIT    = TROW_LSB + TROW_W;

  // Extent in pixels of a sprite dimension stored as "tiles minus one"
  function automatic logic [6:0] span_px(input logic [2:0] size);
    return {1'b0, size, 3'b000} + 7'(TILE_PX);
  endfunction

endpackage

// File: rtl/sprite_slice_pick.sv
// Picks the lowest not-yet-loaded slice word among slices 0..size_x.
// Returns it one-hot together with its binary index (0 when none is left).
module sprite_slice_pick
  import sprite_pkg::*;
(
  input  logic [2:0]         size_x,
  input  logic [SLICE_W-1:0] loaded,
  output logic [SLICE_W-1:0] pick,
  output logic [2:0]         idx
);

  localparam logic [SLICE_W-1:0] ONE = SLICE_W'(1);

  logic [SLICE_W-1:0] cand;
  logic [SLICE_W-1:0] avail;

  // Mask to the sprite width, isolate the lowest free bit and encode it
  always_comb begin
    cand = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      if (3'(i) <= size_x) cand[i] = 1'b1;
    end
    avail = cand & ~loaded;
    pick  = avail & (~avail + ONE);
    idx   = '0;
    for (int i = SLICE_W - 1; i >= 0; i--) begin
      if (avail[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/sprite_eval.sv
// Per-sprite scanline test, on-screen test and next tile-row address.
// Build option: define SPRITE_BYPASS_EN for purely combinational outputs
// (clk and rst then unused); default is one register stage.
module sprite_eval
  import sprite_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            a,
  input  logic [15:0]            b,
  input  logic [2:0]             sizeX,
  input  logic [2:0]             sizeY,
  input  logic                   hFlip,
  input  logic                   vFlip,
  input  logic                   tileTable,
  input  logic [3:0]             tileX,
  input  logic [3:0]             tileY,
  input  logic [9:0]             f,
  input  logic [SLICE_W-1:0]     tile_word_loaded,
  output logic                   xbounded,
  output logic                   yintersect,
  output logic [SLICE_W-1:0]     tile_word_next,
  output logic [TILE_ADDR_W-1:0] tile
);

  logic [6:0]             height_px;
  logic [10:0]            y_top;
  logic [10:0]            y_end;
  logic [5:0]             row_off;
  logic [5:0]             row_sel;
  logic [SLICE_W-1:0]     pick;
  logic [2:0]             slice_idx;
  logic [2:0]             tcol;
  logic [3:0]             tile_col;
  logic [3:0]             tile_row;
  logic                   xb_p0;
  logic                   yint_p0;
  logic [SLICE_W-1:0]     next_p0;
  logic [TILE_ADDR_W-1:0] tile_p0;

  // Upper halves of the coordinate words carry no position information
  logic unused_hi;
  assign unused_hi = ^{a[15:10], b[15:10]};

  sprite_slice_pick u_pick (
    .size_x (sizeX),
    .loaded (tile_word_loaded),
    .pick   (pick),
    .idx    (slice_idx)
  );

  // Stage p0: geometry tests and tile-row address from the current record
  always_comb begin
    height_px = span_px(sizeY);
    y_top     = {1'b0, b[9:0]};
    y_end     = y_top + {4'd0, height_px};
    xb_p0     = {1'b0, a[9:0]} < 11'(SCREEN_W);
    yint_p0   = ({1'b0, f} >= y_top) && ({1'b0, f} < y_end);
    row_off   = 6'(f - b[9:0]);
    row_sel   = vFlip ? (6'(height_px - 7'd1) - row_off) : row_off;
    tcol      = hFlip ? (sizeX - slice_idx) : slice_idx;
    tile_col  = tileX + {1'b0, tcol};
    tile_row  = tileY + {1'b0, row_sel[5:3]};
    next_p0   = yint_p0 ? pick : '0;
    tile_p0   = (yint_p0 && (pick != '0))
                ? {tileTable, tile_row, tile_col, row_sel[2:0]} : '0;
  end

`ifdef SPRITE_BYPASS_EN
  logic unused_clk;
  assign unused_clk = clk ^ rst;

  assign xbounded       = xb_p0;
  assign yintersect     = yint_p0;
  assign tile_word_next = next_p0;
  assign tile           = tile_p0;
`else
  logic                   xb_p1;
  logic                   yint_p1;
  logic [SLICE_W-1:0]     next_p1;
  logic [TILE_ADDR_W-1:0] tile_p1;

  // Stage p1: output register, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xb_p1   <= 1'b0;
      yint_p1 <= 1'b0;
      next_p1 <= '0;
      tile_p1 <= '0;
    end else begin
      xb_p1   <= xb_p0;
      yint_p1 <= yint_p0;
      next_p1 <= next_p0;
      tile_p1 <= tile_p0;
    end
  end

  assign xbounded       = xb_p1;
  assign yintersect     = yint_p1;
  assign tile_word_next = next_p1;
  assign tile           = tile_p1;
`endif

endmodule

// File: tb/tb_sprite_eval.sv
// Self-checking bench for sprite_eval: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_sprite_eval;

  typedef struct packed {
    logic        xb;
    logic        yi;
    logic [7:0]  nx;
    logic [11:0] tl;
  } out_t;

  logic        clk;
  logic        rst;
  logic [15:0] a, b;
  logic [2:0]  sizeX, sizeY;
  logic        hFlip, vFlip, tileTable;
  logic [3:0]  tileX, tileY;
  logic [9:0]  f;
  logic [7:0]  tile_word_loaded;
  logic        xbounded, yintersect;
  logic [7:0]  tile_word_next;
  logic [11:0] tile;

  int   total = 0;
  int   bad   = 0;
  out_t exp_q;
  logic exp_valid;

  sprite_eval dut (
    .clk              (clk),
    .rst              (rst),
    .a                (a),
    .b                (b),
    .sizeX            (sizeX),
    .sizeY            (sizeY),
    .hFlip            (hFlip),
    .vFlip            (vFlip),
    .tileTable        (tileTable),
    .tileX            (tileX),
    .tileY            (tileY),
    .f                (f),
    .tile_word_loaded (tile_word_loaded),
    .xbounded         (xbounded),
    .yintersect       (yintersect),
    .tile_word_next   (tile_word_next),
    .tile             (tile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic over the record rules
  function automatic out_t model();
    out_t o;
    int h, ax, by, s, r, tc;
    h  = 8 * (int'(sizeY) + 1);
    ax = int'(a) % 1024;
    by = int'(b) % 1024;
    o  = '0;
    o.xb = (ax < 640);
    o.yi = (int'(f) >= by) && (int'(f) < by + h);
    s = -1;
    for (int i = 0; i <= int'(sizeX); i++)
      if (s < 0 && tile_word_loaded[i] == 1'b0) s = i;
    if (o.yi && s >= 0) begin
      o.nx = 8'(1 << s);
      r = int'(f) - by;
      if (vFlip) r = h - 1 - r;
      tc = hFlip ? int'(sizeX) - s : s;
      o.tl = 12'(int'(tileTable) * 2048
                 + ((int'(tileY) + r / 8) % 16) * 128
                 + ((int'(tileX) + tc) % 16) * 8
                 + r % 8);
    end
    return o;
  endfunction

  // Model expectation follows the output register, including its async clear
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_valid <= 1'b0;
      exp_q     <= '0;
    end else begin
      exp_valid <= 1'b1;
      exp_q     <= model();
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    out_t got, want;
    logic chk;
    got = {xbounded, yintersect, tile_word_next, tile};
`ifdef SPRITE_BYPASS_EN
    want = model();
    chk  = 1'b1;
`else
    if (!rst) begin
      want = '0;
      chk  = 1'b1;
    end else begin
      want = exp_q;
      chk  = exp_valid;
    end
`endif
    if (chk) begin
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model t=%0t got xb=%b yi=%b next=%h tile=%h want xb=%b yi=%b next=%h tile=%h",
                 $time, got.xb, got.yi, got.nx, got.tl, want.xb, want.yi, want.nx, want.tl);
      end
    end
  end

  task automatic drive(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [2:0] sx, input logic [2:0] sy,
                       input logic hf, input logic vf, input logic tt,
                       input logic [3:0] tx, input logic [3:0] ty,
                       input logic [9:0] ff, input logic [7:0] ld);
    @(negedge clk);
    #1;
    a = ia; b = ib; sizeX = sx; sizeY = sy; hFlip = hf; vFlip = vf;
    tileTable = tt; tileX = tx; tileY = ty; f = ff; tile_word_loaded = ld;
  endtask

  task automatic settle();
`ifdef SPRITE_BYPASS_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic lit(input string nm, input logic xb, input logic yi,
                     input logic [7:0] nx, input logic [11:0] tl);
    total++;
    if ({xbounded, yintersect, tile_word_next, tile} !== {xb, yi, nx, tl}) begin
      bad++;
      $display("FAIL %s got xb=%b yi=%b next=%h tile=%h want xb=%b yi=%b next=%h tile=%h",
               nm, xbounded, yintersect, tile_word_next, tile, xb, yi, nx, tl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    a = 16'd16; b = 16'd100; sizeX = 3'd1; sizeY = 3'd0; hFlip = 1'b0; vFlip = 1'b0;
    tileTable = 1'b0; tileX = 4'd2; tileY = 4'd3; f = 10'd100; tile_word_loaded = 8'h00;
    repeat (2) @(posedge clk);
    #1;
`ifndef SPRITE_BYPASS_EN
    lit("reset_state", 1'b0, 1'b0, 8'h00, 12'h000);
`endif
    @(negedge clk);
    #1;
    rst = 1'b1;

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h00);
    settle();
    lit("base", 1'b1, 1'b1, 8'h01, 12'h190);

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h01);
`ifndef SPRITE_BYPASS_EN
    lit("latency_hold", 1'b1, 1'b1, 8'h01, 12'h190);
`endif
    settle();
    lit("loaded01", 1'b1, 1'b1, 8'h02, 12'h198);

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h03);
    settle();
    lit("loaded03", 1'b1, 1'b1, 8'h00, 12'h000);

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h00);
    settle();
    lit("hflip", 1'b1, 1'b1, 8'h01, 12'h198);

    drive(16'd16, 16'd100, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 10'd103, 8'h00);
    settle();
    lit("vflip", 1'b1, 1'b1, 8'h01, 12'h214);

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd99, 8'h00);
    settle();
    lit("f_above", 1'b1, 1'b0, 8'h00, 12'h000);

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd108, 8'h00);
    settle();
    lit("f_end", 1'b1, 1'b0, 8'h00, 12'h000);

    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd107, 8'h00);
    settle();
    lit("f_last", 1'b1, 1'b1, 8'h01, 12'h197);

    drive(16'd639, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h00);
    settle();
    lit("a639", 1'b1, 1'b1, 8'h01, 12'h190);

    drive(16'd640, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h00);
    settle();
    lit("a640", 1'b0, 1'b1, 8'h01, 12'h190);

    // Upper bits of a/b ignored; loaded bits above sizeX ignored
    drive(16'hFC10, 16'hA864, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'hFC);
    settle();
    lit("hi_bits", 1'b1, 1'b1, 8'h01, 12'h190);

    // Column wraps mod 16, table select in the top bit
    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd3, 10'd100, 8'h01);
    settle();
    lit("col_wrap", 1'b1, 1'b1, 8'h02, 12'h980);

`ifndef SPRITE_BYPASS_EN
    drive(16'd16, 16'd100, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 10'd100, 8'h00);
    settle();
    #2;
    rst = 1'b0;
    #1;
    lit("rst_async", 1'b0, 1'b0, 8'h00, 12'h000);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    lit("rst_release_pre", 1'b0, 1'b0, 8'h00, 12'h000);
    @(posedge clk);
    #1;
    lit("rst_release_post", 1'b1, 1'b1, 8'h01, 12'h190);
`endif

    // Sweep of records around the scanline window, checked by the model
    for (int i = 0; i < 80; i++) begin
      drive(16'($urandom_range(600, 700)), 16'($urandom_range(90, 110)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            10'($urandom_range(85, 180)), 8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
